// File: rtl/dm_wb_slave.sv
// dm_wb_slave: Wishbone classic responder for a word-addressed data RAM with programmable wait states
// dm_clk, dm_rst          : clock, synchronous active-high reset
// dm_i_cyc/stb/we         : bus cycle, strobe, 1 = store
// dm_i_store_addr/data    : store word address and data
// dm_i_load_addr          : load word address
// dm_i_sel                : store byte-lane enables
// dm_o_ack                : one-cycle completion pulse
// dm_o_read_data          : last loaded word
// dm_o_stall              : high while a request is in flight
module dm_wb_slave #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              dm_clk,
  input  logic              dm_rst,
  input  logic              dm_i_cyc,
  input  logic              dm_i_stb,
  input  logic              dm_i_we,
  input  logic [AWIDTH-1:0] dm_i_store_addr,
  input  logic [DWIDTH-1:0] dm_i_store_data,
  input  logic [AWIDTH-1:0] dm_i_load_addr,
  input  logic [3:0]        dm_i_sel,
  output logic              dm_o_ack,
  output logic [DWIDTH-1:0] dm_o_read_data,
  output logic              dm_o_stall
);
  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2;
  logic [1:0] state, state_n;
  logic [3:0] cnt, cnt_n;
  logic idle, accept, access;
  logic l_we, a_we;
  logic [3:0] l_sel, a_sel;
  logic [DWIDTH-1:0] l_data, a_data, wdata;
  logic [AWIDTH-1:0] l_addr, a_addr;
  logic [DWIDTH-1:0] mem [DEPTH];
  // With zero wait states the access happens on the accepting edge, so the
  // access operands come straight from the bus while idle, else from the latches.
  always_comb begin
    idle = state == IDLE;
    accept = idle && dm_i_cyc && dm_i_stb;
    state_n = accept ? (WAIT_CYCLES == 0 ? ACK : WAIT)
            : (state == WAIT && dm_i_cyc) ? (cnt == 4'd1 ? ACK : WAIT) : IDLE;
    access = state_n == ACK;
    cnt_n = accept ? WAIT_LOAD : state_n == WAIT ? cnt - 4'd1 : 4'd0;
    a_we = idle ? dm_i_we : l_we;
    a_sel = idle ? dm_i_sel : l_sel;
    a_data = idle ? dm_i_store_data : l_data;
    a_addr = idle ? (dm_i_we ? dm_i_store_addr : dm_i_load_addr) : l_addr;
    wdata = mem[a_addr];
    for (int b = 0; b < 4; b++)
      wdata[8*b +: 8] = a_sel[b] ? a_data[8*b +: 8] : mem[a_addr][8*b +: 8];
  end
  always_ff @(posedge dm_clk) begin
    if (dm_rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      dm_o_ack <= 1'b0;
      dm_o_stall <= 1'b0;
      dm_o_read_data <= '0;
      l_we <= 1'b0;
      l_sel <= 4'd0;
      l_data <= '0;
      l_addr <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dm_o_ack <= access;
      dm_o_stall <= state_n != IDLE;
      if (accept) begin
        l_we <= dm_i_we;
        l_sel <= dm_i_sel;
        l_data <= dm_i_store_data;
        l_addr <= dm_i_we ? dm_i_store_addr : dm_i_load_addr;
      end
      if (access && !a_we) dm_o_read_data <= mem[a_addr];
    end
  end
  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    always_ff @(posedge dm_clk) begin
      if (dm_rst) mem[w] <= '0;
      else if (access && a_we && a_addr == AWIDTH'(w)) mem[w] <= wdata;
    end
  end
endmodule

// File: tb/tb_dm_wb_slave.sv
// tb_dm_wb_slave: scoreboard bench for dm_wb_slave with 2 and 0 wait states
module tb_dm_wb_slave;
  typedef struct {
    int          edge_n;
    bit          load;
    logic [31:0] data;
  } exp_t;
  localparam int W0 = 2;
  localparam int W1 = 0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc [2];
  logic stb [2];
  logic we [2];
  logic [4:0] saddr [2];
  logic [4:0] laddr [2];
  logic [31:0] sdata [2];
  logic [3:0] sel [2];
  logic ack [2];
  logic stall [2];
  logic [31:0] rd [2];
  int ecnt = 0;
  bit rst_e = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t sb [2][64];
  int head [2];
  int tail [2];
  bit busy [2][32768];
  logic [31:0] mem_m [2][32];
  logic [31:0] rd_m [2];

  dm_wb_slave #(.DWIDTH(32), .AWIDTH(5), .WAIT_CYCLES(W0)) u_w2 (
    .dm_clk(clk), .dm_rst(rst), .dm_i_cyc(cyc[0]), .dm_i_stb(stb[0]), .dm_i_we(we[0]),
    .dm_i_store_addr(saddr[0]), .dm_i_store_data(sdata[0]), .dm_i_load_addr(laddr[0]),
    .dm_i_sel(sel[0]), .dm_o_ack(ack[0]), .dm_o_read_data(rd[0]), .dm_o_stall(stall[0]));
  dm_wb_slave #(.DWIDTH(32), .AWIDTH(5), .WAIT_CYCLES(W1)) u_w0 (
    .dm_clk(clk), .dm_rst(rst), .dm_i_cyc(cyc[1]), .dm_i_stb(stb[1]), .dm_i_we(we[1]),
    .dm_i_store_addr(saddr[1]), .dm_i_store_data(sdata[1]), .dm_i_load_addr(laddr[1]),
    .dm_i_sel(sel[1]), .dm_o_ack(ack[1]), .dm_o_read_data(rd[1]), .dm_o_stall(stall[1]));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    rst_e <= rst;
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d edge %0d got %h expected %h", nm, d, ecnt, act, exp);
    end
  endtask

  // Monitor: after every edge, pop expected acks and compare stall/read_data to the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_e) rd_m[d] = '0;
      while (head[d] != tail[d] && sb[d][head[d] % 64].edge_n < ecnt) begin
        checks++;
        errors++;
        $display("FAIL missing_ack dut%0d expected at edge %0d got none by edge %0d",
                 d, sb[d][head[d] % 64].edge_n, ecnt);
        head[d]++;
      end
      if (ack[d] === 1'b1) begin
        checks++;
        if (head[d] == tail[d] || sb[d][head[d] % 64].edge_n != ecnt) begin
          errors++;
          $display("FAIL unexpected_ack dut%0d got ack at edge %0d expected %0s", d, ecnt,
                   head[d] == tail[d] ? "none" : $sformatf("edge %0d", sb[d][head[d] % 64].edge_n));
        end else begin
          if (sb[d][head[d] % 64].load) rd_m[d] = sb[d][head[d] % 64].data;
          head[d]++;
        end
      end
      chk("stall", d, {31'b0, stall[d]}, {31'b0, busy[d][ecnt]});
      chk("read_data", d, rd[d], rd_m[d]);
    end
  end

  function automatic int wv(input int d);
    return d == 0 ? W0 : W1;
  endfunction

  task automatic push(input int d, input int en, input bit ld, input logic [31:0] dat);
    sb[d][tail[d] % 64] = '{edge_n: en, load: ld, data: dat};
    tail[d]++;
  endtask

  task automatic mark(input int d, input int lo, input int hi);
    for (int e = lo; e <= hi; e++) if (e < 32768) busy[d][e] = 1'b1;
  endtask

  task automatic scramble(input int d);
    stb[d] = 1'($urandom);
    we[d] = 1'($urandom);
    saddr[d] = 5'($urandom);
    laddr[d] = 5'($urandom);
    sdata[d] = $urandom;
    sel[d] = 4'($urandom);
  endtask

  task automatic go_idle(input int d);
    cyc[d] = 1'b0;
    stb[d] = 1'b0;
  endtask

  task automatic drive_req(input int d, input bit w, input logic [4:0] a, input logic [31:0] dat,
                           input logic [3:0] s);
    scramble(d);
    cyc[d] = 1'b1;
    stb[d] = 1'b1;
    we[d] = w;
    sdata[d] = dat;
    sel[d] = s;
    if (w) saddr[d] = a;
    else laddr[d] = a;
  endtask

  task automatic model_store(input int d, input logic [4:0] a, input logic [31:0] dat, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) mem_m[d][a][8*b +: 8] = dat[8*b +: 8];
  endtask

  task automatic xfer(input int d, input bit w, input logic [4:0] a, input logic [31:0] dat,
                      input logic [3:0] s);
    int k = ecnt + 1;
    int wc = wv(d);
    drive_req(d, w, a, dat, s);
    push(d, k + wc, !w, mem_m[d][a]);
    if (w) model_store(d, a, dat, s);
    mark(d, k, k + wc);
    for (int i = 0; i < wc; i++) begin
      @(negedge clk);
      scramble(d);
      cyc[d] = 1'b1;
    end
    @(negedge clk);
    scramble(d);
    cyc[d] = 1'($urandom);
    @(negedge clk);
    go_idle(d);
  endtask

  task automatic interrupt(input int d, input bit use_rst, input bit w, input logic [4:0] a,
                           input logic [31:0] dat, input logic [3:0] s);
    int k = ecnt + 1;
    int j = $urandom_range(0, wv(d) - 1);
    drive_req(d, w, a, dat, s);
    mark(d, k, k + j);
    for (int i = 0; i <= j; i++) begin
      @(negedge clk);
      scramble(d);
      cyc[d] = 1'b1;
    end
    if (use_rst) rst = 1'b1;
    else cyc[d] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    go_idle(d);
    if (use_rst)
      for (int m = 0; m < 2; m++) for (int i = 0; i < 32; i++) mem_m[m][i] = '0;
  endtask

  task automatic hold_loads(input int d, input logic [4:0] a, input int n);
    int k = ecnt + 1;
    int wc = wv(d);
    drive_req(d, 1'b0, a, $urandom, 4'($urandom));
    for (int j = 0; j < n; j++) begin
      push(d, k + j * (wc + 2) + wc, 1'b1, mem_m[d][a]);
      mark(d, k + j * (wc + 2), k + j * (wc + 2) + wc);
    end
    repeat (n * (wc + 2)) @(negedge clk);
    go_idle(d);
  endtask

  task automatic idle_cycles(input int d, input int n);
    repeat (n) begin
      int r = $urandom_range(0, 2);
      scramble(d);
      cyc[d] = r == 1;
      stb[d] = r == 2;
      @(negedge clk);
    end
    go_idle(d);
  endtask

  task automatic random_ops(input int d, input int n);
    repeat (n) begin
      int r = $urandom_range(0, 9);
      if (r <= 3) xfer(d, 1'b1, 5'($urandom), $urandom, 4'($urandom));
      else if (r <= 6 || (r == 7 && wv(d) == 0)) xfer(d, 1'b0, 5'($urandom), 32'h0, 4'($urandom));
      else if (r == 7) interrupt(d, 1'b0, 1'($urandom), 5'($urandom), $urandom, 4'($urandom));
      else if (r == 8) idle_cycles(d, $urandom_range(1, 3));
      else hold_loads(d, 5'($urandom), $urandom_range(2, 4));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      head[d] = 0;
      tail[d] = 0;
      rd_m[d] = '0;
      for (int i = 0; i < 32; i++) mem_m[d][i] = '0;
      scramble(d);
      go_idle(d);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    xfer(0, 1'b0, 5'd7, 32'h0, 4'hf);
    xfer(0, 1'b1, 5'd10, 32'd14, 4'hf);
    xfer(0, 1'b0, 5'd10, 32'h0, 4'h0);
    xfer(0, 1'b1, 5'd3, 32'h11223344, 4'hf);
    xfer(0, 1'b1, 5'd3, 32'hAABBCCDD, 4'b0010);
    xfer(0, 1'b0, 5'd3, 32'h0, 4'h0);
    xfer(0, 1'b1, 5'd3, 32'hFFFFFFFF, 4'b0000);
    xfer(0, 1'b0, 5'd3, 32'h0, 4'hf);
    interrupt(0, 1'b0, 1'b1, 5'd5, 32'hDEAD, 4'hf);
    xfer(0, 1'b0, 5'd5, 32'h0, 4'hf);
    xfer(1, 1'b1, 5'd10, 32'd14, 4'hf);
    hold_loads(1, 5'd10, 6);
    idle_cycles(1, 2);
    interrupt(0, 1'b1, 1'b1, 5'd2, 32'd99, 4'hf);
    xfer(0, 1'b0, 5'd2, 32'h0, 4'hf);
    xfer(1, 1'b0, 5'd10, 32'h0, 4'hf);
    random_ops(0, 150);
    random_ops(1, 150);
    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("drained", d, 32'(tail[d] - head[d]), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_wb_slave.md
# dm_wb_slave

Wishbone classic responder for the data memory behind the memory stage. It accepts single load/store requests from the stage's cyc/stb/we bus, holds them for a programmable number of wait states, then performs the access on a synchronous word-addressed RAM. It returns a one-cycle acknowledge, with read data for loads. It also drives a stall back to the initiator while a request is in flight.

## Interface
- DWIDTH, 32: data word width (must be 32; four byte lanes)
- AWIDTH, 5: word-address width; depth = 2^AWIDTH words
- WAIT_CYCLES, 1: extra wait states before acknowledge, 0..15
---
- dm_clk  in  1  clock; all state changes on rising edge
- dm_rst  in  1  reset, synchronous, active-high
- dm_i_cyc  in  1  bus cycle active
- dm_i_stb  in  1  request strobe
- dm_i_we  in  1  1 = store, 0 = load
- dm_i_store_addr  in  AWIDTH  word address for stores
- dm_i_store_data  in  DWIDTH  store data
- dm_i_load_addr  in  AWIDTH  word address for loads
- dm_i_sel  in  4  byte-lane enables for stores; bit n = bits 8n+7:8n
- dm_o_ack  out  1  single-cycle transfer-complete pulse
- dm_o_read_data  out  DWIDTH  full word read for loads
- dm_o_stall  out  1  responder busy; initiator holds request

## Operation
- The FSM has three states: IDLE, WAIT and ACK.
- **IDLE:**
  - A request is accepted when dm_i_cyc & dm_i_stb is high at an edge.
  - On acceptance, the block latches we, sel and data. It also latches the address: store_addr if we=1, else load_addr.
  - If WAIT_CYCLES=0, go directly to ACK (access performed at this edge). Otherwise load cnt=WAIT_CYCLES and go to WAIT.
- **WAIT:**
  - cnt decrements each edge.
  - At the edge where cnt==1, perform the access and go to ACK.
  - If dm_i_cyc is low at any WAIT edge, the request is aborted: go to IDLE, no memory write, no ack.
- **Access:**
  - Store: for each lane with sel set, write that byte of the latched data. Other lanes keep their value. sel=4'b0000 writes nothing but still acks.
  - Load: dm_o_read_data <= mem[addr] as a full word; sel is ignored.
  - A store does not change dm_o_read_data.
- **ACK:**
  - dm_o_ack=1 for exactly one cycle, then unconditionally go to IDLE.
  - A request still present during ACK is not sampled. It is sampled as a new request at the next edge in IDLE.
- **dm_o_stall:** registered; 1 in WAIT and ACK, 0 in IDLE.
- **dm_o_read_data:** holds its last value until the next load access.
- No address range error is possible; the full 2^AWIDTH space is backed.
- **Reset** (any state, including mid-WAIT):
  - State = IDLE, cnt = 0, dm_o_ack = 0, dm_o_stall = 0, dm_o_read_data = 0.
  - All memory words = 0.
  - A pending store is discarded.
- **Precedence:** reset overrides everything; abort overrides the cnt==1 access in the same cycle.

## Timing
- A request sampled at edge k makes dm_o_ack high during the cycle after edge k+WAIT_CYCLES, for one cycle.
- Read data is valid in that same cycle.
- A store is visible to a load sampled at any later edge.
- Minimum spacing between accepted requests is WAIT_CYCLES+2 edges.
- dm_o_stall rises after edge k and falls after edge k+WAIT_CYCLES+1.
- With WAIT_CYCLES=0, dm_o_stall and dm_o_ack are both high for the single cycle after edge k.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold dm_rst=1 for 2 edges → ack=0, stall=0, read_data=0. Then load addr 7 → read_data=0.
- **Store then load, WAIT_CYCLES=2:**
  - Store addr 10, data 14, sel=1111 sampled at edge k → ack high only after edge k+2; stall high after edges k..k+2.
  - Load addr 10 → read_data=14 in the ack cycle.
- **Byte lanes:**
  - Store 0x11223344 to addr 3 with sel=1111, then store 0xAABBCCDD with sel=0010.
  - Load addr 3 → 0x1122CC44. A store with sel=0000 still acks and leaves 0x1122CC44.
- **Abort:** store addr 5, data 0xDEAD, then drop cyc during WAIT → no ack, stall returns to 0. Load addr 5 → 0.
- **Back-to-back with WAIT_CYCLES=0:**
  - Keep cyc/stb high with a load of addr 10 → ack pulses every 2nd cycle, never on consecutive cycles.
  - read_data=14 on each ack.
- **Reset mid-operation:** store addr 2, data 99; assert dm_rst during WAIT → no ack, stall=0. Load addr 2 → 0.
